// File: rtl/config_pkg.sv
// Shared FP configuration: flag bundle layout, class mask width
// and bit positions of the RISC-V FCLASS result.
package config_pkg;

  localparam int XLEN     = 64;
  localparam int FCLASS_W = 10;

  localparam int FC_NINF  = 0;
  localparam int FC_NNORM = 1;
  localparam int FC_NSUB  = 2;
  localparam int FC_NZERO = 3;
  localparam int FC_PZERO = 4;
  localparam int FC_PSUB  = 5;
  localparam int FC_PNORM = 6;
  localparam int FC_PINF  = 7;
  localparam int FC_SNAN  = 8;
  localparam int FC_QNAN  = 9;

  typedef struct packed {
    logic Xs;
    logic XNaN;
    logic XSNaN;
    logic XSubnorm;
    logic XZero;
    logic XInf;
  } fclass_flags_t;

  // Bundle cannot describe a real operand.
  function automatic logic flags_bad(fclass_flags_t f);
    logic [2:0] n;
    n = 3'(f.XNaN) + 3'(f.XInf)
      + 3'(f.XSubnorm) + 3'(f.XZero);
    return (n > 3'd1) | (f.XSNaN & ~f.XNaN);
  endfunction

endpackage

// File: rtl/fclassify.sv
// Maps an unpacked FP flag bundle to the 10-bit FCLASS mask.
// NaN > Inf > Zero > Subnormal > Normal decides odd bundles.
module fclassify
  import config_pkg::*;
(
  input  fclass_flags_t         flags_i,
  output logic [FCLASS_W-1:0]   class_o
);

  always_comb begin
    class_o = '0;
    if (flags_i.XNaN) begin
      if (flags_i.XSNaN) class_o[FC_SNAN] = 1'b1;
      else               class_o[FC_QNAN] = 1'b1;
    end else if (flags_i.XInf) begin
      if (flags_i.Xs) class_o[FC_NINF] = 1'b1;
      else            class_o[FC_PINF] = 1'b1;
    end else if (flags_i.XZero) begin
      if (flags_i.Xs) class_o[FC_NZERO] = 1'b1;
      else            class_o[FC_PZERO] = 1'b1;
    end else if (flags_i.XSubnorm) begin
      if (flags_i.Xs) class_o[FC_NSUB] = 1'b1;
      else            class_o[FC_PSUB] = 1'b1;
    end else begin
      if (flags_i.Xs) class_o[FC_NNORM] = 1'b1;
      else            class_o[FC_PNORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fclassify_arb.sv
// Round-robin shared FCLASS unit: grant -> S1 flags -> classify
// -> S2 result, returned over a valid/ready handshake.
module fclassify_arb
  import config_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  localparam int SW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      FlushE,
  input  logic [NREQ-1:0]           ReqValid,
  output logic [NREQ-1:0]           ReqReady,
  input  fclass_flags_t [NREQ-1:0]  ReqFlags,
  input  logic [NREQ-1:0][TAGW-1:0] ReqTag,
  output logic                      ResValid,
  input  logic                      ResReady,
  output logic [XLEN-1:0]           ResClass,
  output logic [TAGW-1:0]           ResTag,
  output logic [SW-1:0]             ResSrc,
  output logic                      FlagErr
);

  logic                s1_v_q;
  fclass_flags_t       s1_flags_q;
  logic [TAGW-1:0]     s1_tag_q;
  logic [SW-1:0]       s1_src_q;

  logic                s2_v_q;
  logic [FCLASS_W-1:0] s2_cls_q;
  logic [TAGW-1:0]     s2_tag_q;
  logic [SW-1:0]       s2_src_q;

  logic [SW-1:0]       ptr_q, ptr_d;
  logic                ferr_q, ferr_d;
  logic [SW-1:0]       gnt_idx;
  logic [FCLASS_W-1:0] s1_cls;
  logic                s2_load, s1_free, accept;

  assign s2_load = s1_v_q & (~s2_v_q | ResReady);
  assign s1_free = ~s1_v_q | s2_load;
  assign accept  = s1_free & ~FlushE & (|ReqValid);

  // First requester at or above the pointer, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && ReqValid[idx]) begin
        found   = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

  always_comb begin
    ReqReady = '0;
    if (accept && reset_n) ReqReady[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (gnt_idx == SW'(NREQ - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + 1'b1;
    end
  end

  assign ferr_d = ferr_q
                | (accept & flags_bad(ReqFlags[gnt_idx]));

  fclassify u_fclassify (
    .flags_i (s1_flags_q),
    .class_o (s1_cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      ferr_q <= ferr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q     <= 1'b0;
      s1_flags_q <= '0;
      s1_tag_q   <= '0;
      s1_src_q   <= '0;
    end else if (FlushE) begin
      s1_v_q <= 1'b0;
    end else if (accept) begin
      s1_v_q     <= 1'b1;
      s1_flags_q <= ReqFlags[gnt_idx];
      s1_tag_q   <= ReqTag[gnt_idx];
      s1_src_q   <= gnt_idx;
    end else if (s2_load) begin
      s1_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v_q   <= 1'b0;
      s2_cls_q <= '0;
      s2_tag_q <= '0;
      s2_src_q <= '0;
    end else if (FlushE) begin
      s2_v_q <= 1'b0;
    end else if (s2_load) begin
      s2_v_q   <= 1'b1;
      s2_cls_q <= s1_cls;
      s2_tag_q <= s1_tag_q;
      s2_src_q <= s1_src_q;
    end else if (ResReady) begin
      s2_v_q <= 1'b0;
    end
  end

  assign ResValid = s2_v_q;
  assign ResClass = {{(XLEN - FCLASS_W){1'b0}}, s2_cls_q};
  assign ResTag   = s2_tag_q;
  assign ResSrc   = s2_src_q;
  assign FlagErr  = ferr_q;

endmodule
